// File: rtl/issue_unit_pkg.sv
// Shared CPU execution definitions: result latencies and the issue grant vector.
// Used by the issue unit and by the multiply/divide execution units.
package issue_unit_pkg;

    localparam int MUL_LAT   = 4;
    localparam int DIV_LAT   = 7;
    localparam int DIV_CNT_W = $clog2(DIV_LAT + 1);

    typedef struct packed {
        logic alu;
        logic lsb;
        logic mult;
        logic div;
    } iss_grant_t;

endpackage

// File: rtl/cdb_slot_reserve.sv
// Common data bus slot reservations for multiply/divide results, plus the
// unpipelined divider busy counter and the free-slot queries derived from them.
module cdb_slot_reserve
    import issue_unit_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               mult_issue_i,
    input  logic               div_issue_i,
    output logic               bus_free_o,
    output logic               mult_slot_free_o,
    output logic               div_free_o,
    output logic [DIV_LAT-1:0] slot_map_o
);

    logic [DIV_LAT-1:0]   slot_q, slot_d;
    logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;

    // Bit k set means a result lands on the bus k cycles from now.
    always_comb begin
        slot_d = {1'b0, slot_q[DIV_LAT-1:1]};
        slot_d[MUL_LAT-1] = slot_d[MUL_LAT-1] | mult_issue_i;
        slot_d[DIV_LAT-1] = slot_d[DIV_LAT-1] | div_issue_i;
    end

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (div_issue_i) begin
            div_cnt_d = DIV_CNT_W'(DIV_LAT);
        end else if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - DIV_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q    <= '0;
            div_cnt_q <= '0;
        end else begin
            slot_q    <= slot_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    // A new multiply claims bit MUL_LAT-1 of the next map, i.e. today's bit MUL_LAT.
    assign bus_free_o       = ~slot_q[0];
    assign mult_slot_free_o = ~slot_q[MUL_LAT];
    assign div_free_o       = (div_cnt_q == '0);
    assign slot_map_o       = slot_q;

endmodule

// File: rtl/issue_unit.sv
// Issue arbiter for the common data bus: grants Int/Lsb/Mult/Div with 0-cycle latency.
// Optional ISSUE_RR_FAIRNESS_EN: round-robin Int/Lsb arbitration instead of Int priority.
module issue_unit
    import issue_unit_pkg::*;
(
    input  logic               Clk,
    input  logic               Resetb,
    input  logic               IntQ_Ready,
    input  logic               Lsb_Ready,
    input  logic               MulQ_Ready,
    input  logic               DivQ_Ready,
    output logic               Iss_Int,
    output logic               Iss_Lsb,
    output logic               Iss_Mult,
    output logic               Iss_Div,
    output logic [DIV_LAT-1:0] Iss_SlotMap
);

    iss_grant_t grant_raw;
    iss_grant_t grant_out;
    logic       bus_free;
    logic       mult_slot_free;
    logic       div_free;

    cdb_slot_reserve u_slot_reserve (
        .clk_i            (Clk),
        .rst_ni           (Resetb),
        .mult_issue_i     (grant_raw.mult),
        .div_issue_i      (grant_raw.div),
        .bus_free_o       (bus_free),
        .mult_slot_free_o (mult_slot_free),
        .div_free_o       (div_free),
        .slot_map_o       (Iss_SlotMap)
    );

`ifdef ISSUE_RR_FAIRNESS_EN
    logic rr_ptr_q, rr_ptr_d;

    // Pointer 0 prefers Int; it flips only when both contend for a free bus.
    assign rr_ptr_d = rr_ptr_q ^ (bus_free & IntQ_Ready & Lsb_Ready);

    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_comb begin
        grant_raw      = '0;
        grant_raw.mult = MulQ_Ready & mult_slot_free;
        grant_raw.div  = DivQ_Ready & div_free;
        if (bus_free) begin
`ifdef ISSUE_RR_FAIRNESS_EN
            if (IntQ_Ready && Lsb_Ready) begin
                grant_raw.alu = ~rr_ptr_q;
                grant_raw.lsb = rr_ptr_q;
            end else begin
                grant_raw.alu = IntQ_Ready;
                grant_raw.lsb = Lsb_Ready;
            end
`else
            grant_raw.alu = IntQ_Ready;
            grant_raw.lsb = Lsb_Ready & ~IntQ_Ready;
`endif
        end
    end

    // Reservation state is already held clear in reset; only the visible grants need masking.
    assign grant_out = grant_raw & {4{Resetb}};

    assign Iss_Int  = grant_out.alu;
    assign Iss_Lsb  = grant_out.lsb;
    assign Iss_Mult = grant_out.mult;
    assign Iss_Div  = grant_out.div;

endmodule

// File: tb/tb_issue_unit.sv
// Directed self-checking bench for issue_unit; grants compared as {Int,Lsb,Mult,Div}.
// Expectations for Int/Lsb contention follow ISSUE_RR_FAIRNESS_EN when defined.
module tb_issue_unit;

    logic       Clk;
    logic       Resetb;
    logic       IntQ_Ready, Lsb_Ready, MulQ_Ready, DivQ_Ready;
    logic       Iss_Int, Iss_Lsb, Iss_Mult, Iss_Div;
    logic [6:0] Iss_SlotMap;

    int n_cmp;
    int n_err;

    issue_unit dut (
        .Clk         (Clk),
        .Resetb      (Resetb),
        .IntQ_Ready  (IntQ_Ready),
        .Lsb_Ready   (Lsb_Ready),
        .MulQ_Ready  (MulQ_Ready),
        .DivQ_Ready  (DivQ_Ready),
        .Iss_Int     (Iss_Int),
        .Iss_Lsb     (Iss_Lsb),
        .Iss_Mult    (Iss_Mult),
        .Iss_Div     (Iss_Div),
        .Iss_SlotMap (Iss_SlotMap)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("  ok %s = %0h", tag, got);
        end
    endtask

    function automatic logic [31:0] grants();
        return {28'd0, Iss_Int, Iss_Lsb, Iss_Mult, Iss_Div};
    endfunction

    // Drive the cycle's inputs just after the edge, then settle before sampling.
    task automatic set_in(input logic i, input logic l, input logic m, input logic d);
        IntQ_Ready = i;
        Lsb_Ready  = l;
        MulQ_Ready = m;
        DivQ_Ready = d;
        #3;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Resetb = 1'b0;
        IntQ_Ready = 0; Lsb_Ready = 0; MulQ_Ready = 0; DivQ_Ready = 0;
        repeat (2) @(posedge Clk);
        #1;
        Resetb = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_g;
        n_cmp = 0;
        n_err = 0;
        Resetb = 1'b0;

        // Grants masked and map clear while reset is held, even with every queue ready.
        set_in(1, 1, 1, 1);
        check("reset_grants", grants(), 32'h0);
        check("reset_slotmap", {25'd0, Iss_SlotMap}, 32'h0);
        next_cycle();
        check("reset_grants_c1", grants(), 32'h0);

        // All ready for one cycle: Int, Mult, Div together; map 1001000 afterwards.
        do_reset();
        set_in(1, 1, 1, 1);
        check("all_ready_grants", grants(), 32'b1011);
        next_cycle();
        set_in(0, 0, 0, 0);
        check("all_ready_slotmap", {25'd0, Iss_SlotMap}, 32'b1001000);

        // Multiply at t blocks Int only at t+4.
        do_reset();
        set_in(1, 0, 1, 0);
        check("mul_t0_grants", grants(), 32'b1010);
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            set_in(1, 0, 0, 0);
            check($sformatf("mul_int_t%0d", c), {31'd0, Iss_Int}, (c == 4) ? 32'd0 : 32'd1);
        end

        // Divider held ready: issues every DIV_LAT+1 cycles.
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            set_in(0, 0, 0, 1);
            check($sformatf("div_c%0d", c), {31'd0, Iss_Div}, (c % 8 == 0) ? 32'd1 : 32'd0);
            next_cycle();
        end

        // Div at 0 reserves slot 7, so a multiply at 3 must wait until 4; Int retries.
        do_reset();
        set_in(0, 0, 0, 1);
        check("divmul_div_c0", {31'd0, Iss_Div}, 32'd1);
        next_cycle(); set_in(0, 0, 0, 0);
        next_cycle(); set_in(0, 0, 0, 0);
        next_cycle(); set_in(0, 0, 1, 0);
        check("divmul_mult_c3", {31'd0, Iss_Mult}, 32'd0);
        next_cycle(); set_in(0, 0, 1, 0);
        check("divmul_mult_c4", {31'd0, Iss_Mult}, 32'd1);
        for (int c = 5; c <= 9; c++) begin
            next_cycle();
            set_in(1, 0, 0, 0);
            check($sformatf("divmul_int_c%0d", c), {31'd0, Iss_Int},
                  (c == 7 || c == 8) ? 32'd0 : 32'd1);
        end

        // Int and Lsb contending for four cycles.
        do_reset();
        for (int c = 0; c < 4; c++) begin
`ifdef ISSUE_RR_FAIRNESS_EN
            exp_g = (c % 2 == 0) ? 4'b1000 : 4'b0100;
`else
            exp_g = 4'b1000;
`endif
            set_in(1, 1, 0, 0);
            check($sformatf("intlsb_c%0d", c), grants(), {28'd0, exp_g});
            next_cycle();
        end
        set_in(0, 1, 0, 0);
        check("lsb_alone", grants(), 32'b0100);

        // Reset mid-operation with pending reservations 0101000.
        do_reset();
        set_in(0, 0, 0, 1);
        next_cycle(); set_in(0, 0, 1, 0);
        next_cycle(); set_in(1, 1, 1, 1);
        check("midrst_slotmap_before", {25'd0, Iss_SlotMap}, 32'b0101000);
        Resetb = 1'b0;
        #1;
        check("midrst_slotmap_during", {25'd0, Iss_SlotMap}, 32'h0);
        check("midrst_grants_during", grants(), 32'h0);
        next_cycle();
        Resetb = 1'b1;
        set_in(1, 0, 0, 0);
        check("midrst_int_after", grants(), 32'b1000);
        check("midrst_slotmap_after", {25'd0, Iss_SlotMap}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
